// File: rtl/return_addr_stack_if.sv
`default_nettype none
// ============================================================================
// Module   : return_addr_stack_if
// Brief    : Decode/writeback/execute-side signal bundle for return_addr_stack.
// Revision : 1.0 - initial release
// ============================================================================
interface return_addr_stack_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 18,
  parameter int NCKPT = 4
);
  localparam int c_KW = (NCKPT > 1) ? $clog2(NCKPT) : 1;
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic            push;
  logic [AW-1:0]   push_addr;
  logic            pop;
  logic            ovr_valid;
  logic [AW-1:0]   ovr_addr;
  logic            ckpt_save;
  logic [c_KW-1:0] ckpt_id;
  logic            restore;
  logic [c_KW-1:0] restore_id;
  logic [AW-1:0]   top_addr;
  logic            top_valid;
  logic [c_CW-1:0] count;
  logic            ovf;
  logic            unf;

  modport master (
    output push, push_addr, pop, ovr_valid, ovr_addr,
           ckpt_save, ckpt_id, restore, restore_id,
    input  top_addr, top_valid, count, ovf, unf
  );

  modport slave (
    input  push, push_addr, pop, ovr_valid, ovr_addr,
           ckpt_save, ckpt_id, restore, restore_id,
    output top_addr, top_valid, count, ovf, unf
  );
endinterface
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module   : return_addr_stack
// Brief    : Circular return-address stack with top override and checkpoints.
// Revision : 1.0 - initial release
// ============================================================================
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 18,
  parameter int NCKPT = 4
) (
  input  wire logic            clk,
  input  wire logic            reset,
  return_addr_stack_if.slave   bus
);
  localparam int c_PW    = $clog2(DEPTH);
  localparam int c_CW    = c_PW + 1;
  localparam int c_KW    = (NCKPT > 1) ? $clog2(NCKPT) : 1;
  localparam int c_NSLOT = 1 << c_KW;
  localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(DEPTH);

  logic [c_PW-1:0] r_ptr;
  logic [c_CW-1:0] r_cnt;
  logic [AW-1:0]   r_mem    [DEPTH];
  logic [c_PW-1:0] r_ck_ptr [c_NSLOT];
  logic [c_CW-1:0] r_ck_cnt [c_NSLOT];
  logic [AW-1:0]   r_ck_top [c_NSLOT];
  logic            r_ovf;
  logic            r_unf;

  logic [c_PW-1:0] w_ptr_n;
  logic [c_CW-1:0] w_cnt_n;
  logic            w_wr_en;
  logic [AW-1:0]   w_wr_data;
  logic [AW-1:0]   w_top_n;
  logic            w_ovf_n;
  logic            w_unf_n;
  logic            w_empty;

  assign w_empty = (r_cnt == '0);

  // Every write this cycle lands on the next-cycle top, so the write index is w_ptr_n.
  always_comb begin
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    w_wr_en   = 1'b0;
    w_wr_data = bus.push_addr;
    w_ovf_n   = 1'b0;
    w_unf_n   = 1'b0;
    if (bus.restore) begin
      w_ptr_n   = r_ck_ptr[bus.restore_id];
      w_cnt_n   = r_ck_cnt[bus.restore_id];
      w_wr_en   = 1'b1;
      w_wr_data = r_ck_top[bus.restore_id];
    end else if (bus.push && (!bus.pop || w_empty)) begin
      w_ptr_n = r_ptr + c_PTR_ONE;
      w_wr_en = 1'b1;
      if (r_cnt == c_CNT_FULL) begin
        w_ovf_n = 1'b1;
      end else begin
        w_cnt_n = r_cnt + c_CNT_ONE;
      end
    end else if (bus.push) begin
      w_wr_en = 1'b1;
    end else if (bus.pop) begin
      if (w_empty) begin
        w_unf_n = 1'b1;
      end else begin
        w_ptr_n = r_ptr - c_PTR_ONE;
        w_cnt_n = r_cnt - c_CNT_ONE;
      end
    end
    if (bus.ovr_valid) begin
      w_wr_en   = 1'b1;
      w_wr_data = bus.ovr_addr;
      if (w_cnt_n == '0) begin
        w_cnt_n = c_CNT_ONE;
      end
    end
    w_top_n = w_wr_en ? w_wr_data : r_mem[w_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      for (int i = 0; i < c_NSLOT; i++) begin
        r_ck_ptr[i] <= '0;
        r_ck_cnt[i] <= '0;
        r_ck_top[i] <= '0;
      end
    end else begin
      r_ptr <= w_ptr_n;
      r_cnt <= w_cnt_n;
      r_ovf <= w_ovf_n;
      r_unf <= w_unf_n;
      if (w_wr_en) begin
        r_mem[w_ptr_n] <= w_wr_data;
      end
      if (bus.ckpt_save && !bus.restore) begin
        r_ck_ptr[bus.ckpt_id] <= w_ptr_n;
        r_ck_cnt[bus.ckpt_id] <= w_cnt_n;
        r_ck_top[bus.ckpt_id] <= w_top_n;
      end
    end
  end

  assign bus.top_addr  = r_mem[r_ptr];
  assign bus.top_valid = !w_empty;
  assign bus.count     = r_cnt;
  assign bus.ovf       = r_ovf;
  assign bus.unf       = r_unf;
endmodule
`default_nettype wire

// File: doc/return_addr_stack.md
# return_addr_stack

Parametrised return-address stack for the dual-issue core front end, generalising the single-entry `ra_cache` to a circular stack of `DEPTH` entries. Decode pushes on calls and pops on returns. Writeback can correct the top entry when `ra` is loaded from memory. Execute can restore the stack to a per-branch checkpoint on a branch mispredict. The top entry drives the fetch PC mux for `JumpR` redirects with zero added latency.

## Interface
- `DEPTH`, default 8: stack entries; power of two, ≥2.
- `AW`, default 18: address width; matches the PC width.
- `NCKPT`, default 4: checkpoint slots; power of two, ≥1.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  call decoded (JAL/JALR with rd=ra); slot-1/slot-2 arbitration is done outside this block.
- `push_addr`  in  AW  return address (PC+4 of the call slot).
- `pop`  in  1  return decoded (JALR rs1=ra, rd≠ra).
- `ovr_valid`  in  1  writeback of a load into `ra`.
- `ovr_addr`  in  AW  loaded value, low AW bits.
- `ckpt_save`  in  1  branch decoded; snapshot the stack state.
- `ckpt_id`  in  log2(NCKPT)  slot to write on `ckpt_save`.
- `restore`  in  1  mispredict in execute.
- `restore_id`  in  log2(NCKPT)  slot to restore from.
- `top_addr`  out  AW  current top entry.
- `top_valid`  out  1  count≠0.
- `count`  out  log2(DEPTH)+1  valid entries.
- `ovf`  out  1  one-cycle pulse: a push overwrote the oldest entry.
- `unf`  out  1  one-cycle pulse: a pop occurred at count=0.

## Operation
- State:
  - `ptr` (log2 DEPTH bits, index of top entry).
  - `count`.
  - `mem[DEPTH]` of AW bits.
  - `NCKPT` checkpoints, each {ptr, count, top value}.
- Per-cycle op, from {push, pop}:
  - push only: `ptr`←ptr+1 (mod DEPTH); `mem[ptr+1]`←push_addr; `count`←min(count+1, DEPTH). If count was DEPTH, the oldest entry is silently overwritten and `ovf`=1.
  - pop only, count>0: `ptr`←ptr−1 (mod DEPTH); `count`←count−1. Memory is unchanged.
  - pop only, count=0: no state change; `unf`=1.
  - push & pop (co-routine JALR ra,ra): `mem[ptr]`←push_addr. `ptr` and `count` are unchanged, except at count=0, where it behaves as a plain push.
- `ovr_valid`: writes `mem[ptr']`←ovr_addr, where ptr' is the pointer after this cycle's op.
  - If count' is 0, count becomes 1.
  - In the push&pop replace case, `ovr` wins over `push_addr`.
- `ckpt_save`: slot `ckpt_id` ← {ptr', count', value written/held at mem[ptr']}. This is the state in effect next cycle, including `ovr`.
- `restore`: has priority over push, pop and ckpt_save; those are ignored that cycle.
  - `ptr`←saved ptr; `count`←saved count; `mem[saved ptr]`←saved top.
  - `ovr_valid` is still applied afterwards to the restored top.
  - `ovf`/`unf` are 0 in a restore cycle.
- Entries below top that were overwritten after a checkpoint are not recovered; only the top entry is repaired.
- All arithmetic on `ptr` wraps modulo DEPTH. `count` saturates at DEPTH and does not go below 0.

## Timing
- `top_addr` = mem[ptr], `top_valid`, and `count` are combinational from registers. All updates become visible the cycle after the input.
- No internal bypass from `push_addr` to `top_addr` in the same cycle; the core's decode bypass handles same-cycle use.
- `ovf`/`unf` are registered and asserted the cycle after the causing op, for exactly one cycle.
- Reset, synchronous and active-high, dominant over every input:
  - ptr, count, all mem entries and all checkpoints ← 0.
  - `top_addr`=0, `top_valid`=0, `count`=0, `ovf`=0, `unf`=0.
- Reset asserted mid-sequence discards all pending state. The first op after release sees an empty stack.
- No stall input: the caller gates `push`/`pop`/`ckpt_save` with its own stall/enable (core_en & ~StallD).

## Test plan
- Reset, then push 0x100, 0x108, 0x110 → next cycle `top_addr`=0x110, `count`=3. Three pops → top 0x108, then 0x100, then `top_valid`=0. A fourth pop gives `unf`=1 and `count`=0.
- DEPTH=8: push 0x8 through 0x48 (9 values) → `ovf`=1 on the 9th, `count`=8, top 0x48. Eight pops return 0x40 down to 0x10; the value 0x8 is lost.
- Push 0x200, then push&pop with 0x300 → `count`=1, top 0x300.
- Same cycle push 0x400 with `ovr_valid`=1, ovr_addr 0x500 → top 0x500, `count`=1.
- Push 0x100, `ckpt_save` id 2, pop, push 0x900, push 0x980, then `restore` id 2 with a push asserted → `count`=1, top 0x100; the push is ignored.
- Push, push, then `reset` together with a push → next cycle `count`=0, `top_addr`=0, `top_valid`=0.
